uart_rx_word_assembler: RTL and testbench
=========================================

Name: uart_rx_word_assembler

Overview:
Downstream stage of the UART receiver. It consumes the receiver's byte stream (Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR) and packs NUM_BYTES consecutive good bytes into one word. The finished word is held for the consumer behind a valid/ack handshake. Errored bytes and inter-byte timeouts abort the partial word, and bytes that arrive while a word is held are dropped and flagged as overrun.

Parameters:
NUM_BYTES, 4, bytes per word (2..8)
TIMEOUT_CYCLES, 500000, max clk cycles between bytes of one word before the partial word is abandoned (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
Rx_DATA  input  8  received byte from the UART receiver
Rx_VALID  input  1  receiver byte-valid; may be a pulse or a level held for several cycles
Rx_FERROR  input  1  framing error for the current byte
Rx_PERROR  input  1  parity error for the current byte
word_out  output  8*NUM_BYTES  assembled word; first-received byte in the MSBs
word_valid  output  1  word_out is complete and stable
word_ack  input  1  consumer accepts word_out
word_error  output  1  one-cycle pulse: partial word discarded (bad byte or timeout)
overrun  output  1  one-cycle pulse: byte dropped because a word was held
byte_count  output  clog2(NUM_BYTES+1)  bytes collected in the current partial word

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high. Reset mid-operation discards all state.
- Values after reset: word_out=0, word_valid=0, word_error=0, overrun=0, byte_count=0, state IDLE, timeout counter 0.
- Byte event: a byte event is the rising edge of Rx_VALID, detected with a registered copy of Rx_VALID that resets to 0. Exactly one event per frame, regardless of how long Rx_VALID stays high. Rx_DATA and the error flags are sampled in the event cycle.
- A byte is bad when Rx_FERROR or Rx_PERROR is set at its event.
- IDLE:
  - good byte: shift it in, byte_count=1, go to COLLECT
  - bad byte: pulse word_error, stay in IDLE
- COLLECT:
  - good byte: shift left by 8 and insert into the LSBs; byte_count+1; timeout counter cleared.
  - good byte that makes byte_count reach NUM_BYTES: next cycle word_valid=1, byte_count=0, state HOLD.
  - bad byte: pulse word_error, clear the shift register and byte_count, go to IDLE.
  - no event: the timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1: pulse word_error, clear, go to IDLE.
  - A byte event in the same cycle as the timeout: the byte wins and the counter clears.
- HOLD:
  - word_out stays stable while word_valid=1.
  - word_ack=1: word_valid drops next cycle, go to IDLE.
  - byte event without ack: byte dropped, overrun pulses, word_out unchanged.
  - byte event with ack in the same cycle: word is released and the byte is processed as in IDLE. A good byte becomes byte 0 of the next word (state COLLECT); a bad byte pulses word_error. No overrun in either case.
- word_ack outside HOLD is ignored.
- Latency: word_valid rises 1 clk after the event of the last byte.
- word_error and overrun never last longer than 1 cycle. They may both assert in the same cycle only through separate causes, which this FSM excludes.
- Timeout counter is wide enough for TIMEOUT_CYCLES and never wraps. It saturates and clears on state exit.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2) and the clog2 width helper.
- One natural sub-module, uart_rx_edge_detect: Rx_VALID rising-edge pulse generator, reusable on the transmitter side.
- FSM, shift register and timeout counter stay in the top module.

Test Plan:
- Good bytes 0xDE,0xAD,0xBE,0xEF -> word_out=0xDEADBEEF, word_valid=1 one clk after the 4th event; byte_count steps 1,2,3, then 0.
- Rx_VALID held high 20 cycles per byte over 4 bytes -> exactly 4 events, a single word, no duplicated bytes.
- Bytes 0x11,0x22, then 0x33 with Rx_PERROR=1 -> word_error one-cycle pulse, byte_count=0. The next 4 good bytes 0x01..0x04 -> word_out=0x01020304.
- TIMEOUT_CYCLES=16: one byte 0xAA, then silence -> word_error pulses 16 cycles after the event, state IDLE, no word_valid.
- Word 0xCAFEF00D held with word_ack=0; a 5th byte 0x55 arrives -> overrun pulse, word_out still 0xCAFEF00D. Then word_ack in the same cycle as byte 0x77 -> word_valid falls, byte_count=1, no overrun.
- reset asserted mid-word (after 2 bytes) and while in HOLD -> all outputs 0 on the next clk, and the next 4 bytes assemble cleanly.

Source files
------------

// File: rtl/uart_rx_word_assembler_pkg.sv
// Shared types and helpers for the UART receive word assembler.
// Holds the FSM state encoding and the counter width helper.
package uart_rx_word_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Bits needed to hold any value in 0..max_value.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/uart_rx_edge_detect.sv
// Turns a byte-valid level or pulse into a single-cycle rising-edge event.
// Reusable wherever a strobe may be held high for several cycles.
module uart_rx_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs NUM_BYTES good UART bytes into one word (first byte in the MSBs) and
// holds it behind a valid/ack handshake; bad bytes and timeouts abort the word.
module uart_rx_word_assembler
    import uart_rx_word_assembler_pkg::*;
#(
    parameter int NUM_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [7:0]                          Rx_DATA,
    input  logic                                Rx_VALID,
    input  logic                                Rx_FERROR,
    input  logic                                Rx_PERROR,
    output logic [8*NUM_BYTES-1:0]              word_out,
    output logic                                word_valid,
    input  logic                                word_ack,
    output logic                                word_error,
    output logic                                overrun,
    output logic [count_width(NUM_BYTES)-1:0]   byte_count
);

    localparam int WORD_W = 8 * NUM_BYTES;
    localparam int BC_W   = count_width(NUM_BYTES);
    localparam int TMR_W  = count_width(TIMEOUT_CYCLES);

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] shift_q;
    logic [BC_W-1:0]   byte_count_q;
    logic [TMR_W-1:0]  timer_q;
    logic              word_valid_q;
    logic              word_error_q;
    logic              overrun_q;

    logic byte_event;
    logic byte_bad;
    logic last_byte;
    logic timeout_hit;

    logic start_word;
    logic shift_byte;
    logic complete_word;
    logic clear_word;
    logic release_word;
    logic error_set;
    logic overrun_set;

    uart_rx_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (Rx_VALID),
        .pulse (byte_event)
    );

    assign byte_bad    = Rx_FERROR | Rx_PERROR;
    assign last_byte   = (byte_count_q == BC_W'(NUM_BYTES - 1));
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (byte_event && !byte_bad) state_d = COLLECT;
            end
            COLLECT: begin
                if (byte_event) begin
                    if (byte_bad)       state_d = IDLE;
                    else if (last_byte) state_d = HOLD;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // An ack releases the word; a coincident byte starts the next one.
                if (word_ack) begin
                    state_d = (byte_event && !byte_bad) ? COLLECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_word    = 1'b0;
        shift_byte    = 1'b0;
        complete_word = 1'b0;
        clear_word    = 1'b0;
        release_word  = 1'b0;
        error_set     = 1'b0;
        overrun_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (byte_event) begin
                    if (byte_bad) error_set  = 1'b1;
                    else          start_word = 1'b1;
                end
            end
            COLLECT: begin
                if (byte_event) begin
                    if (byte_bad) begin
                        error_set  = 1'b1;
                        clear_word = 1'b1;
                    end else if (last_byte) begin
                        complete_word = 1'b1;
                    end else begin
                        shift_byte = 1'b1;
                    end
                end else if (timeout_hit) begin
                    error_set  = 1'b1;
                    clear_word = 1'b1;
                end
            end
            HOLD: begin
                if (word_ack) begin
                    release_word = 1'b1;
                    if (byte_event) begin
                        if (byte_bad) error_set  = 1'b1;
                        else          start_word = 1'b1;
                    end
                end else if (byte_event) begin
                    overrun_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= '0;
            byte_count_q <= '0;
            word_valid_q <= 1'b0;
            word_error_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            word_error_q <= error_set;
            overrun_q    <= overrun_set;
            if (start_word) begin
                shift_q      <= WORD_W'(Rx_DATA);
                byte_count_q <= BC_W'(1);
            end else if (shift_byte || complete_word) begin
                shift_q      <= {shift_q[WORD_W-9:0], Rx_DATA};
                byte_count_q <= complete_word ? '0 : byte_count_q + BC_W'(1);
            end else if (clear_word) begin
                shift_q      <= '0;
                byte_count_q <= '0;
            end
            if (complete_word)     word_valid_q <= 1'b1;
            else if (release_word) word_valid_q <= 1'b0;
        end
    end

    // Inter-byte timer: runs only while collecting, saturates, clears on any byte or exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (byte_event || state_d != COLLECT) begin
            timer_q <= '0;
        end else if (!timeout_hit) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    assign word_out   = shift_q;
    assign word_valid = word_valid_q;
    assign word_error = word_error_q;
    assign overrun    = overrun_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed self-checking bench for uart_rx_word_assembler (4-byte words).
// A second instance with a short timeout exercises the inter-byte timeout.
module tb_uart_rx_word_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  Rx_DATA;
    logic        Rx_VALID;
    logic        Rx_FERROR;
    logic        Rx_PERROR;
    logic        word_ack;

    logic [31:0] word_out;
    logic        word_valid;
    logic        word_error;
    logic        overrun;
    logic [2:0]  byte_count;

    logic [31:0] to_word_out;
    logic        to_word_valid;
    logic        to_word_error;
    logic        to_overrun;
    logic [2:0]  to_byte_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_word_assembler #(.NUM_BYTES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_FERROR  (Rx_FERROR),
        .Rx_PERROR  (Rx_PERROR),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ack   (word_ack),
        .word_error (word_error),
        .overrun    (overrun),
        .byte_count (byte_count)
    );

    uart_rx_word_assembler #(.NUM_BYTES(4), .TIMEOUT_CYCLES(16)) dut_to (
        .clk        (clk),
        .reset      (reset),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_FERROR  (Rx_FERROR),
        .Rx_PERROR  (Rx_PERROR),
        .word_out   (to_word_out),
        .word_valid (to_word_valid),
        .word_ack   (word_ack),
        .word_error (to_word_error),
        .overrun    (to_overrun),
        .byte_count (to_byte_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One low cycle, then Rx_VALID high for 'hold' cycles; returns 1ns after the last high edge.
    task automatic applyStimulus(input logic [7:0] data, input logic ferr, input logic perr,
                                 input int hold, input logic ack);
        Rx_VALID = 1'b0;
        tick();
        Rx_DATA   = data;
        Rx_FERROR = ferr;
        Rx_PERROR = perr;
        Rx_VALID  = 1'b1;
        word_ack  = ack;
        tick();
        word_ack  = 1'b0;
        Rx_FERROR = 1'b0;
        Rx_PERROR = 1'b0;
        for (int i = 1; i < hold; i++) tick();
        Rx_VALID = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        Rx_DATA = 8'h00; Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0; word_ack = 1'b0;
        do_reset();
        checks++;
        if ({word_out, word_valid, word_error, overrun, byte_count} !== 38'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h/%b/%b/%b/%0d required 0/0/0/0/0",
                     word_out, word_valid, word_error, overrun, byte_count);
        end
    endtask

    task automatic test_basic_word();
        logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bytes[i], 1'b0, 1'b0, 1, 1'b0);
            checks++;
            if (byte_count !== 3'((i + 1) % 4)) begin
                failures++;
                $display("[TB] FAIL basic_count[%0d]: got %0d required %0d", i, byte_count, (i + 1) % 4);
            end
            checks++;
            if (word_valid !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL basic_valid[%0d]: got %b required %b", i, word_valid, i == 3);
            end
        end
        checks++;
        if (word_out !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL basic_word: got %h required DEADBEEF", word_out);
        end
        word_ack = 1'b1;
        tick();
        word_ack = 1'b0;
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_ack: word_valid got %b required 0", word_valid);
        end
    endtask

    task automatic test_held_valid();
        logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bytes[i], 1'b0, 1'b0, 20, 1'b0);
            checks++;
            if (byte_count !== 3'((i + 1) % 4)) begin
                failures++;
                $display("[TB] FAIL held_count[%0d]: got %0d required %0d", i, byte_count, (i + 1) % 4);
            end
        end
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL held_word: got %b/%h required 1/12345678", word_valid, word_out);
        end
        tick();
        word_ack = 1'b1;
        tick();
        word_ack = 1'b0;
    endtask

    task automatic test_bad_byte();
        logic [7:0] bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        applyStimulus(8'h11, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b1, 1, 1'b0);
        checks++;
        if (word_error !== 1'b1 || byte_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL perr_abort: error/count got %b/%0d required 1/0", word_error, byte_count);
        end
        tick();
        checks++;
        if (word_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL perr_pulse_width: word_error got %b required 0", word_error);
        end
        for (int i = 0; i < 4; i++) applyStimulus(bytes[i], 1'b0, 1'b0, 1, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h01020304) begin
            failures++;
            $display("[TB] FAIL after_error_word: got %b/%h required 1/01020304", word_valid, word_out);
        end
        word_ack = 1'b1;
        tick();
        word_ack = 1'b0;
        applyStimulus(8'h99, 1'b1, 1'b0, 1, 1'b0);
        checks++;
        if (word_error !== 1'b1 || byte_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL idle_ferr: error/count got %b/%0d required 1/0", word_error, byte_count);
        end
    endtask

    task automatic test_timeout();
        int first_seen = -1;
        int pulses     = 0;
        do_reset();
        applyStimulus(8'hAA, 1'b0, 1'b0, 1, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (to_word_error === 1'b1) begin
                pulses++;
                if (first_seen < 0) first_seen = k;
            end
        end
        checks++;
        if (first_seen != 16 || pulses != 1) begin
            failures++;
            $display("[TB] FAIL timeout_pulse: first at %0d (%0d pulses) required 16 (1 pulse)",
                     first_seen, pulses);
        end
        checks++;
        if (to_byte_count !== 3'd0 || to_word_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_idle: count/valid got %0d/%b required 0/0", to_byte_count, to_word_valid);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        do_reset();
        for (int i = 0; i < 4; i++) applyStimulus(bytes[i], 1'b0, 1'b0, 1, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, 1, 1'b0);
        checks++;
        if (overrun !== 1'b1 || word_valid !== 1'b1 || word_out !== 32'hCAFEF00D) begin
            failures++;
            $display("[TB] FAIL overrun_hold: ovr/valid/word got %b/%b/%h required 1/1/CAFEF00D",
                     overrun, word_valid, word_out);
        end
        tick();
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_pulse_width: got %b required 0", overrun);
        end
        applyStimulus(8'h77, 1'b0, 1'b0, 1, 1'b1);
        checks++;
        if (word_valid !== 1'b0 || byte_count !== 3'd1 || overrun !== 1'b0 || word_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ack_with_byte: valid/count/ovr/err got %b/%0d/%b/%b required 0/1/0/0",
                     word_valid, byte_count, overrun, word_error);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        do_reset();
        applyStimulus(8'h10, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0, 1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({word_out, word_valid, word_error, overrun, byte_count} !== 38'd0) begin
            failures++;
            $display("[TB] FAIL reset_midword: got %h/%b/%0d required 0/0/0", word_out, word_valid, byte_count);
        end
        for (int i = 0; i < 4; i++) applyStimulus(bytes[i], 1'b0, 1'b0, 1, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h5AA53CC3) begin
            failures++;
            $display("[TB] FAIL after_reset_word: got %b/%h required 1/5AA53CC3", word_valid, word_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({word_out, word_valid, word_error, overrun, byte_count} !== 38'd0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %h/%b/%0d required 0/0/0", word_out, word_valid, byte_count);
        end
        for (int i = 3; i >= 0; i--) applyStimulus(bytes[i], 1'b0, 1'b0, 1, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'hC33CA55A) begin
            failures++;
            $display("[TB] FAIL after_hold_reset_word: got %b/%h required 1/C33CA55A", word_valid, word_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic_word();
        test_held_valid();
        test_bad_byte();
        test_timeout();
        test_overrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
